// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier with start/busy/done handshake.
// Each product is also sent on tx as a start bit, LSB-first data and a stop bit.
module booth_multiplier_seq #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 tx
);

  localparam int unsigned FrameBits = 2 * WIDTH + 2;
  localparam int unsigned IdxW      = $clog2(FrameBits);
  localparam int unsigned CntW      = $clog2(WIDTH + 2);
  localparam int unsigned BaudW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StTx} state_e;

  state_e               state_q, state_d;
  logic [WIDTH:0]       a_q, a_d, m_q, m_d, q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [BaudW-1:0]     baud_q, baud_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 done_q, done_d;
  logic                 tx_q, tx_d;

  logic [WIDTH:0]       sum, a_sh, q_sh;
  logic [FrameBits-1:0] frame;

  // One Booth step: conditional add/subtract, then arithmetic shift of {A,Q,Q-1}.
  always_comb begin
    case ({q_q[0], qm1_q})
      2'b01:   sum = a_q + m_q;
      2'b10:   sum = a_q - m_q;
      default: sum = a_q;
    endcase
    a_sh = {sum[WIDTH], sum[WIDTH:1]};
    q_sh = {sum[0], q_q[WIDTH:1]};
  end

  assign frame = {1'b1, product_q, 1'b0};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    baud_d    = baud_q;
    product_d = product_q;
    done_d    = 1'b0;
    tx_d      = tx_q;
    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (start) begin
          m_d     = {signed_mode & multiplicand[WIDTH-1], multiplicand};
          q_d     = {signed_mode & multiplier[WIDTH-1], multiplier};
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = CntW'(WIDTH + 1);
          state_d = StCalc;
        end
      end
      StCalc: begin
        a_d   = a_sh;
        q_d   = q_sh;
        qm1_d = q_q[0];
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          // Last iteration: publish the product and drive the start bit on the same edge.
          product_d = {a_sh[WIDTH-2:0], q_sh};
          done_d    = 1'b1;
          tx_d      = 1'b0;
          idx_d     = '0;
          baud_d    = '0;
          state_d   = StTx;
        end
      end
      StTx: begin
        if (baud_q == BaudW'(CLKS_PER_BIT - 1)) begin
          baud_d = '0;
          if (idx_q == IdxW'(FrameBits - 1)) begin
            tx_d    = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + IdxW'(1);
            tx_d  = frame[idx_d];
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      baud_q    <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      baud_q    <= baud_d;
      product_q <= product_d;
      done_q    <= done_d;
      tx_q      <= tx_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign product = product_q;
  assign tx      = tx_q;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Bench for booth_multiplier_seq: two instances (W=4/1 clk per bit, W=8/4 clks per bit)
// checked cycle by cycle against an arithmetic product model and the serial frame layout.
module tb_booth_multiplier_seq;

  localparam int unsigned WA = 4;
  localparam int unsigned CA = 1;
  localparam int unsigned WB = 8;
  localparam int unsigned CB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, sm_a = 1'b0;
  logic [3:0]  mr_a = '0, md_a = '0;
  logic        busy_a, done_a, tx_a;
  logic [7:0]  product_a;

  logic        start_b = 1'b0, sm_b = 1'b0;
  logic [7:0]  mr_b = '0, md_b = '0;
  logic        busy_b, done_b, tx_b;
  logic [15:0] product_b;

  booth_multiplier_seq #(.WIDTH(WA), .CLKS_PER_BIT(CA)) u_dut_a (
    .CLK(clk), .RST_N(rst_n), .start(start_a), .signed_mode(sm_a),
    .multiplier(mr_a), .multiplicand(md_a),
    .busy(busy_a), .done(done_a), .product(product_a), .tx(tx_a)
  );

  booth_multiplier_seq #(.WIDTH(WB), .CLKS_PER_BIT(CB)) u_dut_b (
    .CLK(clk), .RST_N(rst_n), .start(start_b), .signed_mode(sm_b),
    .multiplier(mr_b), .multiplicand(md_b),
    .busy(busy_b), .done(done_b), .product(product_b), .tx(tx_b)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          op_id = 0;
  logic [15:0] prev_prod [2];

  task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got {busy,done,tx,product}=%h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] obs(input int sel);
    if (sel == 1) return {busy_b, done_b, tx_b, product_b};
    return {busy_a, done_a, tx_a, 8'h00, product_a};
  endfunction

  // Signed or unsigned product of w-bit operands, truncated to 2w bits.
  function automatic logic [15:0] ref_prod(input int w, input logic sm,
                                           input logic [7:0] mr, input logic [7:0] md);
    longint x, y, p;
    x = longint'(mr) & ((longint'(1) << w) - 1);
    y = longint'(md) & ((longint'(1) << w) - 1);
    if (sm && x[w-1]) x = x - (longint'(1) << w);
    if (sm && y[w-1]) y = y - (longint'(1) << w);
    p = (x * y) & ((longint'(1) << (2 * w)) - 1);
    return 16'(p);
  endfunction

  function automatic logic fbit(input int j, input int w, input logic [15:0] p);
    if (j == 0) return 1'b0;
    if (j == 2 * w + 1) return 1'b1;
    return p[j-1];
  endfunction

  task automatic drive(input int sel, input logic st, input logic sm,
                       input logic [7:0] mr, input logic [7:0] md);
    if (sel == 1) begin
      start_b = st; sm_b = sm; mr_b = mr; md_b = md;
    end else begin
      start_a = st; sm_a = sm; mr_a = mr[3:0]; md_a = md[3:0];
    end
  endtask

  // Launch one op and check every cycle until the frame ends. With hold, start stays high
  // and operands are scrambled mid-calc; otherwise start and operands are randomised while busy.
  task automatic run_op(input int sel, input logic sm, input logic [7:0] mr,
                        input logic [7:0] md, input logic [15:0] exp, input bit hold);
    int          w;
    int          c;
    int          k_end;
    logic [18:0] e;
    w     = (sel == 1) ? WB : WA;
    c     = (sel == 1) ? CB : CA;
    k_end = w + 1 + (2 * w + 2) * c;
    op_id++;
    drive(sel, 1'b1, sm, mr, md);
    @(posedge clk); #1;
    check($sformatf("op%0d_accept", op_id), obs(sel), {3'b101, prev_prod[sel]});
    for (int k = 1; k <= k_end; k++) begin
      if (hold) begin
        if (k == 2) drive(sel, 1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
      end else begin
        drive(sel, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      end
      @(posedge clk); #1;
      if (k <= w) e = {3'b101, prev_prod[sel]};
      else if (k < k_end) e = {1'b1, (k == w + 1), fbit((k - w - 1) / c, w, exp), exp};
      else e = {3'b001, exp};
      check($sformatf("op%0d_k%0d", op_id, k), obs(sel), e);
    end
    prev_prod[sel] = exp;
    if (!hold) drive(sel, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Start an op, assert reset between edges after the given number of edges.
  task automatic reset_mid(input int sel, input int edges);
    op_id++;
    drive(sel, 1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
    @(posedge clk);
    repeat (edges) @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, 8'h00, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check($sformatf("op%0d_rst_a", op_id), obs(0), {3'b001, 16'h0000});
    check($sformatf("op%0d_rst_b", op_id), obs(1), {3'b001, 16'h0000});
    prev_prod[0] = '0;
    prev_prod[1] = '0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic       sm;
    logic [7:0] mr, md;
    prev_prod[0] = '0;
    prev_prod[1] = '0;
    #12;
    check("reset_a", obs(0), {3'b001, 16'h0000});
    check("reset_b", obs(1), {3'b001, 16'h0000});
    #1 rst_n = 1'b1;

    run_op(0, 1'b1, 8'h07, 8'h0E, 16'h00F2, 1'b0);
    run_op(0, 1'b1, 8'h0F, 8'h02, 16'h00FE, 1'b0);
    run_op(0, 1'b1, 8'h08, 8'h08, 16'h0040, 1'b0);
    run_op(0, 1'b0, 8'h0F, 8'h0F, 16'h00E1, 1'b0);
    run_op(0, 1'b0, 8'h0E, 8'h07, 16'h0062, 1'b0);
    run_op(0, 1'b1, 8'h0E, 8'h07, 16'h00F2, 1'b0);
    run_op(0, 1'b1, 8'h00, 8'h05, 16'h0000, 1'b0);
    run_op(0, 1'b0, 8'h00, 8'h00, 16'h0000, 1'b0);
    run_op(0, 1'b1, 8'h07, 8'h0E, 16'h00F2, 1'b1);
    run_op(0, 1'b0, 8'h0F, 8'h0F, 16'h00E1, 1'b0);

    run_op(1, 1'b1, 8'h80, 8'h7F, 16'hC080, 1'b0);
    run_op(1, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0);
    run_op(1, 1'b1, 8'h80, 8'h80, 16'h4000, 1'b0);

    reset_mid(0, 2);
    run_op(0, 1'b1, 8'h07, 8'h0E, 16'h00F2, 1'b0);
    reset_mid(0, WA + 3);
    run_op(0, 1'b0, 8'h0F, 8'h0F, 16'h00E1, 1'b0);
    reset_mid(1, 20);
    run_op(1, 1'b1, 8'h80, 8'h7F, 16'hC080, 1'b0);

    for (int i = 0; i < 28; i++) begin
      sm = 1'($urandom);
      mr = 8'($urandom) & 8'h0F;
      md = 8'($urandom) & 8'h0F;
      run_op(0, sm, mr, md, ref_prod(WA, sm, mr, md), (i % 4) == 1);
    end
    for (int i = 0; i < 6; i++) begin
      sm = 1'($urandom);
      mr = 8'($urandom);
      md = 8'($urandom);
      run_op(1, sm, mr, md, ref_prod(WB, sm, mr, md), i == 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/booth_multiplier_seq.md
Name: booth_multiplier_seq

Overview:
Parametrised sequential radix-2 Booth multiplier with a start/busy/done handshake and a per-operation signed/unsigned mode. After each multiply it transmits the product serially on `tx` as a framed, UART-style word at a parametrised bit period. It replaces the fixed 4-bit booth_multiplier in the arithmetic datapath. Operands are latched at start, so upstream logic may change its inputs freely while the block is busy.

Parameters:
WIDTH, 4, operand width in bits (≥2); product is 2*WIDTH bits.
CLKS_PER_BIT, 1, CLK cycles per serial bit on `tx` (≥1).

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST_N  input  1  asynchronous active-low reset
start  input  1  request pulse/level; sampled only when busy=0
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; latched with operands
multiplier  input  WIDTH  multiplier operand
multiplicand  input  WIDTH  multiplicand operand
busy  output  1  high from accepted start until serial frame stop bit completes
done  output  1  one-cycle pulse when product updates
product  output  2*WIDTH  registered result; holds until next done
tx  output  1  serial output, idles high

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE, busy=0, done=0, product=0, tx=1, all internal registers 0. Reset asserted mid-CALC or mid-TX aborts immediately with no partial product or frame.
- FSM states:
  - IDLE: tx=1, busy=0.
  - CALC
  - TX
- IDLE→CALC: on edge E0 with start=1. At E0:
  - M = multiplicand extended to WIDTH+1 bits, sign-extended if signed_mode=1, else zero-extended.
  - Q = multiplier extended the same way.
  - A = 0 (WIDTH+1 bits), Q-1 = 0, count = WIDTH+1.
  - busy=1 after E0.
- CALC, one Booth iteration per edge (E1..E(WIDTH+1)):
  - {Q0,Q-1}=01: A=A+M.
  - {Q0,Q-1}=10: A=A−M.
  - 00/11: A unchanged.
  - Then arithmetic shift right of {A,Q,Q-1} by 1 (A MSB replicated). Additions are modulo 2^(WIDTH+1).
  - count decrements each iteration.
- CALC→TX on E(WIDTH+1), the edge performing the last iteration:
  - product = low 2*WIDTH bits of the final {A,Q}.
  - done=1 for the following cycle only.
  - Latency: product valid and done high WIDTH+1 cycles after the accepting edge.
- TX:
  - Frame: start bit 0, then product bits LSB first (2*WIDTH bits), then stop bit 1.
  - Each bit is held CLKS_PER_BIT cycles, beginning at the same edge done rises.
  - After the stop bit period ends: state=IDLE, busy=0, tx=1.
- Total busy duration: (WIDTH+1) + (2*WIDTH+2)*CLKS_PER_BIT cycles.
- start while busy=1 is ignored (not queued). Operand and signed_mode changes while busy have no effect.
- start held high continuously: a new operation is accepted on the first edge where busy=0. That edge is also the idle edge, so there is no idle gap beyond one cycle of tx=1.
- Boundary cases (must be exact):
  - Signed most-negative × most-negative, e.g. W=4: −8×−8 = +64.
  - Unsigned all-ones operands.
  - Zero operands.
  - done and the tx start bit coincide; product never changes during TX.

Test Plan:
- W=4, signed_mode=1, multiplier=0111 (7), multiplicand=1110 (−2), start 1 cycle -> done 5 cycles after accept, product=8'hF2 (−14), tx frame 0,0,1,0,0,1,1,1,1,1 (start, data LSB first, stop), busy low after 15 cycles.
- W=4, signed, multiplier=1111 (−1), multiplicand=0010 (2) -> product=8'hFE; then signed 1000×1000 -> product=8'h40.
- W=4, unsigned, 1111×1111 -> product=8'hE1 (225); unsigned 1110×0111 -> 8'h62 (98); same bits signed -> 8'hF2.
- start held high across two ops with operands changed mid-CALC -> first product uses latched operands; second op accepted on first busy=0 edge; done pulses exactly once per op.
- CLKS_PER_BIT=4, W=8, signed 0x80×0x7F -> product=16'hC080, each tx bit 4 cycles, busy=9+18*4=81 cycles.
- RST_N low mid-CALC and mid-TX (asynchronous, between edges) -> tx=1, busy=0, done=0, product=0 immediately; a fresh start after release completes correctly.
